maxpool2x2_window: RTL and testbench

- Streaming 2x2/stride-2 max-pooling datapath.
- Consumes a row-major raster of one WIDTH x WIDTH feature map, one pixel per enabled cycle.
- Emits one pooled value per 2x2 window.
- Keeps its own row/column position counters; keeps one half-width row buffer of horizontal pair maxima.
- Sits between the convolution/activation output stream and the next layer's input stream.

---
 rtl/pool_pkg.sv | 15 +
 rtl/maxpool2x2_window_if.sv | 15 +
 rtl/maxpool2x2_window_row_buffer.sv | 24 ++
 rtl/maxpool2x2_window.sv | 74 +++++++
 tb/tb_maxpool2x2_window.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/pool_pkg.sv
// Shared definitions for the pooling blocks: default pixel width, position
// counter width and a signed two-input maximum.
package pool_pkg;

  localparam int DATA_W = 16;
  localparam int CNT_W  = 10;
  // max2 works on a wide signed type; callers sign-extend in and truncate out.
  localparam int MAX_W  = 64;

  function automatic logic signed [MAX_W-1:0] max2(input logic signed [MAX_W-1:0] a,
                                                   input logic signed [MAX_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/maxpool2x2_window_if.sv
// Pixel stream in / pooled stream out for the 2x2 max-pool window.
// enable qualifies data_in for exactly one cycle; out_valid qualifies data_out
// for exactly one cycle. There is no ready: the sink must take every pulse.
interface maxpool2x2_window_if #(
  parameter int DATA_W = pool_pkg::DATA_W
);
  logic                     enable;
  logic signed [DATA_W-1:0] data_in;
  logic signed [DATA_W-1:0] data_out;
  logic                     out_valid;
  logic                     frame_done;

  modport master (output enable, data_in, input data_out, out_valid, frame_done);
  modport slave  (input enable, data_in, output data_out, out_valid, frame_done);
endinterface

// File: rtl/maxpool2x2_window_row_buffer.sv
// Half-width line store of horizontal pair maxima from the even row of each
// window pair; written on even rows and read asynchronously on odd rows.
module pool_row_buffer #(
  parameter int DATA_W = pool_pkg::DATA_W,
  parameter int DEPTH  = 16,
  parameter int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [AW-1:0]            waddr,
  input  logic signed [DATA_W-1:0] wdata,
  input  logic [AW-1:0]            raddr,
  output logic signed [DATA_W-1:0] rdata
);

  logic signed [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/maxpool2x2_window.sv
// Streaming 2x2 / stride-2 signed max pool over a square WIDTH x WIDTH raster,
// one pixel per enabled cycle, one registered result per window.
module maxpool2x2_window
  import pool_pkg::*;
#(
  parameter int DATA_W = pool_pkg::DATA_W,
  parameter int WIDTH  = 32
) (
  input logic                 clk,
  input logic                 reset,
  maxpool2x2_window_if.slave  bus
);

  localparam int HALF = WIDTH / 2;
  localparam int AW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  if ((WIDTH % 2) != 0 || WIDTH < 2 || WIDTH > (1 << CNT_W)) begin : g_bad_width
    $error("maxpool2x2_window: WIDTH must be even, >= 2 and fit the position counters");
  end

  logic [CNT_W-1:0]         c, r;
  logic signed [DATA_W-1:0] hold;
  logic signed [DATA_W-1:0] pair_max, row_max, pool_max;
  logic                     buf_we;

  assign pair_max = DATA_W'(max2(MAX_W'(hold), MAX_W'(bus.data_in)));
  assign pool_max = DATA_W'(max2(MAX_W'(row_max), MAX_W'(pair_max)));
  assign buf_we   = reset && bus.enable && c[0] && !r[0];

  pool_row_buffer #(
    .DATA_W (DATA_W),
    .DEPTH  (HALF),
    .AW     (AW)
  ) u_row_buffer (
    .clk   (clk),
    .we    (buf_we),
    .waddr (c[AW:1]),
    .wdata (pair_max),
    .raddr (c[AW:1]),
    .rdata (row_max)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      c              <= '0;
      r              <= '0;
      hold           <= '0;
      bus.data_out   <= '0;
      bus.out_valid  <= 1'b0;
      bus.frame_done <= 1'b0;
    end else begin
      bus.out_valid  <= 1'b0;
      bus.frame_done <= 1'b0;
      if (bus.enable) begin
        // Even column opens a pair; odd column closes it (buffer it or emit).
        if (!c[0]) begin
          hold <= bus.data_in;
        end else if (r[0]) begin
          bus.data_out   <= pool_max;
          bus.out_valid  <= 1'b1;
          bus.frame_done <= (r == LAST) && (c == LAST);
        end
        if (c == LAST) begin
          c <= '0;
          r <= (r == LAST) ? '0 : r + 1'b1;
        end else begin
          c <= c + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_maxpool2x2_window.sv
// Directed and random stimulus for maxpool2x2_window at WIDTH=4 and WIDTH=32,
// with a window-level reference model feeding an expected-output queue.
module tb_maxpool2x2_window;

  localparam int DW = 16;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   mon_on = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  maxpool2x2_window_if #(.DATA_W(DW)) b4  ();
  maxpool2x2_window_if #(.DATA_W(DW)) b32 ();

  maxpool2x2_window #(.DATA_W(DW), .WIDTH(4))  dut4  (.clk(clk), .reset(reset), .bus(b4.slave));
  maxpool2x2_window #(.DATA_W(DW), .WIDTH(32)) dut32 (.clk(clk), .reset(reset), .bus(b32.slave));

  // Scoreboard entries are {frame_done, data_out}; arrival cycle kept alongside.
  logic [DW:0] exp_q4[$];
  logic [DW:0] exp_q32[$];
  int          cyc_q4[$];
  int          cyc_q32[$];

  logic signed [DW-1:0] fr [2][32][32];
  int mr [2];
  int mc [2];

  task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic signed [DW-1:0] smax(input logic signed [DW-1:0] a, input logic signed [DW-1:0] b);
    return (a >= b) ? a : b;
  endfunction

  // s=0 drives the WIDTH=4 instance, s=1 the WIDTH=32 instance.
  task automatic drive(input int s, input bit en, input logic signed [DW-1:0] px);
    int w, rr, cc;
    logic signed [DW-1:0] m;
    logic [DW:0] e;
    @(negedge clk);
    b4.enable  = (s == 0) ? en : 1'b0;
    b4.data_in = (s == 0) ? px : '0;
    b32.enable  = (s == 1) ? en : 1'b0;
    b32.data_in = (s == 1) ? px : '0;
    if (en) begin
      w  = (s == 0) ? 4 : 32;
      rr = mr[s];
      cc = mc[s];
      fr[s][rr][cc] = px;
      if ((rr % 2 == 1) && (cc % 2 == 1)) begin
        m = smax(smax(fr[s][rr-1][cc-1], fr[s][rr-1][cc]), smax(fr[s][rr][cc-1], px));
        e = {((rr == w-1) && (cc == w-1)), m};
        if (s == 0) begin exp_q4.push_back(e);  cyc_q4.push_back(cyc + 1);  end
        else        begin exp_q32.push_back(e); cyc_q32.push_back(cyc + 1); end
      end
      if (cc == w-1) begin
        mc[s] = 0;
        mr[s] = (rr == w-1) ? 0 : rr + 1;
      end else begin
        mc[s] = cc + 1;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 1'b0, '0);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    reset = 1'b0;
    b4.enable  = 1'b0;
    b32.enable = 1'b0;
    mr = '{0, 0};
    mc = '{0, 0};
    @(negedge clk);
    chk({tag, "_dout"},  int'(b4.data_out), 0);
    chk({tag, "_valid"}, int'(b4.out_valid), 0);
    chk({tag, "_fdone"}, int'(b4.frame_done), 0);
    reset = 1'b1;
  endtask

  always @(negedge clk) begin
    logic [DW:0] e;
    int ec;
    if (mon_on) begin
      if (b4.out_valid === 1'b1) begin
        chk("w4_unexpected_valid", int'(exp_q4.size() > 0), 1);
        if (exp_q4.size() > 0) begin
          e  = exp_q4.pop_front();
          ec = cyc_q4.pop_front();
          chk("w4_data", int'(b4.data_out), int'($signed(e[DW-1:0])));
          chk("w4_frame_done", int'(b4.frame_done), int'(e[DW]));
          chk("w4_latency", cyc, ec);
        end
      end else begin
        chk("w4_idle_frame_done", int'(b4.frame_done), 0);
      end
      if (b32.out_valid === 1'b1) begin
        chk("w32_unexpected_valid", int'(exp_q32.size() > 0), 1);
        if (exp_q32.size() > 0) begin
          e  = exp_q32.pop_front();
          ec = cyc_q32.pop_front();
          chk("w32_data", int'(b32.data_out), int'($signed(e[DW-1:0])));
          chk("w32_frame_done", int'(b32.frame_done), int'(e[DW]));
          chk("w32_latency", cyc, ec);
        end
      end
    end
  end

  initial begin
    int n4;
    logic signed [DW-1:0] v;
    reset = 1'b0;
    b4.enable = 1'b0;   b4.data_in = '0;
    b32.enable = 1'b0;  b32.data_in = '0;
    mr = '{0, 0};
    mc = '{0, 0};
    repeat (2) @(negedge clk);
    do_reset("reset");
    mon_on = 1'b1;

    // Ramp frame 0..15, enable held high.
    for (int i = 0; i < 16; i++) drive(0, 1'b1, DW'(i));
    idle(3);

    // Signed frame: all -100 except (r=2,c=1) = -3.
    for (int i = 0; i < 16; i++) drive(0, 1'b1, (i == 9) ? -16'sd3 : -16'sd100);
    idle(3);

    // Ramp with enable toggling 1,0,1,0.
    for (int i = 0; i < 16; i++) begin
      drive(0, 1'b1, DW'(i));
      drive(0, 1'b0, 16'h7fff);
    end
    idle(3);

    // Partial frame discarded by a mid-frame reset, then a full ramp 100..115.
    for (int i = 0; i < 10; i++) drive(0, 1'b1, DW'(i));
    do_reset("midreset");
    for (int i = 100; i < 116; i++) drive(0, 1'b1, DW'(i));
    idle(3);

    // Two frames back to back: 0..15 then 16..31.
    for (int i = 0; i < 32; i++) drive(0, 1'b1, DW'(i));
    idle(3);
    chk("w4_drain", exp_q4.size(), 0);
    n4 = checks;

    // Random WIDTH=32 frame with random stalls.
    for (int i = 0; i < 1024; i++) begin
      if ($urandom_range(0, 3) == 0) drive(1, 1'b0, '0);
      v = DW'($urandom);
      drive(1, 1'b1, v);
    end
    repeat (4) drive(1, 1'b0, '0);
    chk("w32_drain", exp_q32.size(), 0);
    chk("w32_checked_something", int'(checks - n4 > 768), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
